// File: rtl/ct_rd_upsizer.sv
// Read-side upsizer: packs WIDTH-bit beats from a CDC FIFO into RATIO-lane words.
// Optional idle-timeout flush of partial words is enabled with `define CT_UPSIZER_TIMEOUT_EN.
module ct_rd_upsizer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         rdclk,
  input  logic                         rdarst,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_eop,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [WIDTH*RATIO-1:0]       o_data,
  output logic [$clog2(RATIO+1)-1:0]   o_count,
  output logic                         o_eop,
  output logic                         o_valid,
  input  logic                         i_ready
);

  localparam int IDX_W  = $clog2(RATIO);
  localparam int CNT_W  = $clog2(RATIO+1);
  localparam int WORD_W = WIDTH * RATIO;

  if (RATIO < 2 || RATIO > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("ct_rd_upsizer: RATIO must be 2..16 and TIMEOUT 1..65535");
  end

  function automatic logic [WORD_W-1:0] put_lane(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  lane,
    input logic [WIDTH-1:0]  beat
  );
    logic [WORD_W-1:0] r;
    r = word;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == IDX_W'(k)) r[k*WIDTH +: WIDTH] = beat;
    end
    return r;
  endfunction

  // Lanes at or above the valid count always leave the block as zero.
  function automatic logic [WORD_W-1:0] keep_lanes(
    input logic [WORD_W-1:0] word,
    input logic [CNT_W-1:0]  n
  );
    logic [WORD_W-1:0] r;
    r = word;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) >= n) r[k*WIDTH +: WIDTH] = '0;
    end
    return r;
  endfunction

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] acc;

  logic [WORD_W-1:0] data_p1;
  logic [CNT_W-1:0]  count_p1;
  logic              eop_p1;
  logic              vld_p1;

  logic              out_free;
  logic              flush;
  logic              accept;
  logic              last_lane;
  logic              closing;
  logic              load;
  logic [CNT_W-1:0]  ld_count;
  logic [WORD_W-1:0] ld_data;

  assign out_free = !vld_p1 || i_ready;

`ifdef CT_UPSIZER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT+1);
  logic [TO_W-1:0] idle_cnt;

  // The flush cycle takes the output register, so no beat may be accepted then.
  assign flush   = (idx != '0) && (idle_cnt == TO_W'(TIMEOUT)) && out_free;
  assign o_ready = out_free && !flush;

  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) begin
      idle_cnt <= '0;
    end else if (load || accept || (idx == '0)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_W'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign flush   = 1'b0;
  assign o_ready = out_free;
`endif

  // ---- p0: beat acceptance and word assembly ----
  assign accept    = i_valid && o_ready;
  assign last_lane = (idx == IDX_W'(RATIO-1));
  assign closing   = accept && (last_lane || i_eop);
  assign load      = closing || flush;

  always_comb begin
    ld_count = CNT_W'(idx);
    ld_data  = keep_lanes(acc, CNT_W'(idx));
    if (closing) begin
      ld_count = CNT_W'(idx) + CNT_W'(1);
      ld_data  = keep_lanes(put_lane(acc, idx, i_data), CNT_W'(idx) + CNT_W'(1));
    end
  end

  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) begin
      idx <= '0;
      acc <= '0;
    end else if (load) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      idx <= idx + IDX_W'(1);
      acc <= put_lane(acc, idx, i_data);
    end
  end

  // ---- p1: output word register ----
  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) begin
      data_p1  <= '0;
      count_p1 <= '0;
      eop_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (load) begin
      data_p1  <= ld_data;
      count_p1 <= ld_count;
      eop_p1   <= closing && i_eop;
      vld_p1   <= 1'b1;
    end else if (vld_p1 && i_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign o_data  = data_p1;
  assign o_count = count_p1;
  assign o_eop   = eop_p1;
  assign o_valid = vld_p1;

endmodule

// File: tb/tb_ct_rd_upsizer.sv
// Self-checking bench for ct_rd_upsizer (WIDTH=8, RATIO=4, TIMEOUT=5) with a
// queue-based packetising reference model.
module tb_ct_rd_upsizer;

  localparam int WIDTH   = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 5;

  logic        rdclk = 1'b0;
  logic        rdarst = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_eop = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_eop;
  logic        o_valid;
  logic        i_ready = 1'b1;

  always #5 rdclk = ~rdclk;

  ct_rd_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .rdclk(rdclk), .rdarst(rdarst), .i_data(i_data), .i_eop(i_eop),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_count(o_count),
    .o_eop(o_eop), .o_valid(o_valid), .i_ready(i_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
    logic        eop;
  } word_t;

  int n_checks = 0;
  int n_fail   = 0;

  word_t      exp_q[$];
  word_t      got_q[$];
  logic [7:0] mdl_lanes[$];
  int         mdl_idle;

  logic        s_valid, s_ready, s_eop, s_exp_ready;
  logic [31:0] s_data;
  logic [2:0]  s_count;

  function automatic word_t pack_word(input logic eop);
    word_t w;
    w.data = 32'h0;
    for (int i = 0; i < mdl_lanes.size(); i++)
      w.data = w.data | (32'(mdl_lanes[i]) << (8 * i));
    w.count = 3'(mdl_lanes.size());
    w.eop   = eop;
    return w;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    mdl_lanes.delete();
    mdl_idle = 0;
  endtask

  // One clock cycle: drive, sample outputs mid-cycle, advance the reference model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic e, input logic r);
    logic  out_free;
    logic  flush_now;
    word_t w;
    @(negedge rdclk);
    i_valid = v; i_data = d; i_eop = e; i_ready = r;
    #1;
    s_valid = o_valid; s_data = o_data; s_count = o_count; s_eop = o_eop; s_ready = o_ready;
    out_free  = !s_valid || r;
    flush_now = 1'b0;
`ifdef CT_UPSIZER_TIMEOUT_EN
    flush_now = out_free && (mdl_lanes.size() != 0) && (mdl_idle == TIMEOUT);
`endif
    s_exp_ready = out_free && !flush_now;
    if (s_valid && r) begin
      w.data = s_data; w.count = s_count; w.eop = s_eop;
      got_q.push_back(w);
    end
    if (flush_now) begin
      exp_q.push_back(pack_word(1'b0));
      mdl_lanes.delete();
      mdl_idle = 0;
    end else if (v && s_ready) begin
      mdl_lanes.push_back(d);
      mdl_idle = 0;
      if (mdl_lanes.size() == RATIO || e) begin
        exp_q.push_back(pack_word(e));
        mdl_lanes.delete();
      end
    end else if (mdl_lanes.size() != 0) begin
      if (mdl_idle < TIMEOUT) mdl_idle++;
    end else begin
      mdl_idle = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge rdclk);
    rdarst = 1'b1; i_valid = 1'b0; i_eop = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge rdclk);
    rdarst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    @(negedge rdclk);
    i_valid = 1'b0;
    #2 rdarst = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 00000000", o_data); end
    n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
    n_checks++; if (o_eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop got %b want 0", o_eop); end
    @(negedge rdclk);
    rdarst = 1'b0;
    clear_model();
  endtask

  task automatic test_full_word();
    apply_reset();
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %b want 0", s_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", s_valid); end
    n_checks++; if (s_data !== 32'h44332211) begin n_fail++; $display("FAIL full_data got %h want 44332211", s_data); end
    n_checks++; if (s_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", s_count); end
    n_checks++; if (s_eop !== 1'b0) begin n_fail++; $display("FAIL full_eop got %b want 0", s_eop); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL full_clear got %b want 0", s_valid); end
  endtask

  task automatic test_eop();
    apply_reset();
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL eop2_valid got %b want 1", s_valid); end
    n_checks++; if (s_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL eop2_data got %h want 0000bbaa", s_data); end
    n_checks++; if (s_count !== 3'd2) begin n_fail++; $display("FAIL eop2_count got %0d want 2", s_count); end
    n_checks++; if (s_eop !== 1'b1) begin n_fail++; $display("FAIL eop2_eop got %b want 1", s_eop); end
    cycle(1'b1, 8'hCC, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_data !== 32'h000000CC) begin n_fail++; $display("FAIL single_data got %h want 000000cc", s_data); end
    n_checks++; if (s_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", s_count); end
    n_checks++; if (s_eop !== 1'b1 || s_valid !== 1'b1) begin n_fail++; $display("FAIL single_eop got eop=%b valid=%b want 1 1", s_eop, s_valid); end
  endtask

  task automatic test_back_to_back();
    int words;
    apply_reset();
    words = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(i < 12, 8'($urandom), 1'b0, 1'b1);
      if (s_valid) words++;
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cycle %0d got %b want 1", i, s_ready); end
      n_checks++;
      if (s_valid !== (i >= 4 && i % 4 == 0)) begin
        n_fail++; $display("FAIL b2b_valid cycle %0d got %b want %b", i, s_valid, (i >= 4 && i % 4 == 0));
      end
    end
    n_checks++; if (words != 3) begin n_fail++; $display("FAIL b2b_words got %0d want 3", words); end
    n_checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_qsize got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_q[k].data !== exp_q[k].data || got_q[k].count !== exp_q[k].count) begin
          n_fail++; $display("FAIL b2b_word%0d got %h/%0d want %h/%0d", k, got_q[k].data, got_q[k].count, exp_q[k].data, exp_q[k].count);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", s_ready); end
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== 32'h04030201 || s_count !== 3'd4 || s_eop !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold got v=%b %h/%0d/%b want 1 04030201/4/0", s_valid, s_data, s_count, s_eop);
      end
    end
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    n_checks++; if (s_ready !== 1'b1 || s_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release got ready=%b valid=%b want 1 1", s_ready, s_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", s_valid); end
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h00006655 || s_count !== 3'd2) begin
      n_fail++; $display("FAIL bp_same_cycle got v=%b %h/%0d want 1 00006655/2", s_valid, s_data, s_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(1'b1, 8'hA1, 1'b0, 1'b1);
    cycle(1'b1, 8'hA2, 1'b0, 1'b1);
    @(negedge rdclk);
    i_valid = 1'b0;
    #2 rdarst = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_out got valid=%b ready=%b want 0 1", o_valid, o_ready); end
    @(negedge rdclk);
    rdarst = 1'b0;
    clear_model();
    cycle(1'b1, 8'hB1, 1'b0, 1'b1);
    cycle(1'b1, 8'hB2, 1'b0, 1'b1);
    cycle(1'b1, 8'hB3, 1'b0, 1'b1);
    cycle(1'b1, 8'hB4, 1'b0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got %b want 0", s_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 32'hB4B3B2B1 || s_count !== 3'd4) begin
      n_fail++; $display("FAIL rstmid_word got v=%b %h/%0d want 1 b4b3b2b1/4", s_valid, s_data, s_count);
    end
  endtask

`ifdef CT_UPSIZER_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (s_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle%0d got valid=%b ready=%b want 0 1", k, s_valid, s_ready); end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (s_ready !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL to_flush got ready=%b valid=%b want 0 0", s_ready, s_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h00000077 || s_count !== 3'd1 || s_eop !== 1'b0) begin
      n_fail++; $display("FAIL to_word got v=%b %h/%0d/%b want 1 00000077/1/0", s_valid, s_data, s_count, s_eop);
    end
  endtask
`else
  task automatic test_hold_partial();
    apply_reset();
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (s_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle%0d got valid=%b ready=%b want 0 1", k, s_valid, s_ready); end
    end
    cycle(1'b1, 8'h88, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h00008877 || s_count !== 3'd2 || s_eop !== 1'b1) begin
      n_fail++; $display("FAIL hold_word got v=%b %h/%0d/%b want 1 00008877/2/1", s_valid, s_data, s_count, s_eop);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 75);
      n_checks++; if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL rand_ready cycle %0d got %b want %b", i, s_ready, s_exp_ready); end
    end
    for (int i = 0; i < 20; i++) cycle(mdl_lanes.size() != 0, 8'($urandom), 1'b1, 1'b1);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d words want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k].data !== exp_q[k].data || got_q[k].count !== exp_q[k].count || got_q[k].eop !== exp_q[k].eop) begin
          n_fail++; $display("FAIL rand_word%0d got %h/%0d/%b want %h/%0d/%b", k, got_q[k].data, got_q[k].count, got_q[k].eop, exp_q[k].data, exp_q[k].count, exp_q[k].eop);
        end
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_full_word();
    test_eop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef CT_UPSIZER_TIMEOUT_EN
    test_timeout();
`else
    test_hold_partial();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
